// File: rtl/shifter_pkg.sv
// Shared definitions for the pipelined barrel shifter: operation encodings and width helper.
package shifter_pkg;

    typedef enum logic [2:0] {
        OP_ROL = 3'b000,
        OP_SLL = 3'b001,
        OP_ROR = 3'b010,
        OP_SRL = 3'b011,
        OP_SRA = 3'b100
    } op_e;

    // Ceiling log2, used for count width and pipeline depth.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/shift_stage.sv
// One level of the barrel shifter: conditional shift by AMT followed by a valid/ready register slot.
module shift_stage
    import shifter_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned TAG_W = 4,
    parameter int unsigned AMT   = 1,
    localparam int unsigned CNT_W = clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] din,
    input  logic [2:0]       op_in,
    input  logic [CNT_W-1:0] cnt_in,
    input  logic [TAG_W-1:0] tag_in,
    input  logic             carry_in,
    input  logic             sh,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] dout,
    output logic [2:0]       op_out,
    output logic [CNT_W-1:0] cnt_out,
    output logic [TAG_W-1:0] tag_out,
    output logic             carry_out
);

    logic             valid_q;
    logic [WIDTH-1:0] data_q;
    logic [2:0]       op_q;
    logic [CNT_W-1:0] cnt_q;
    logic [TAG_W-1:0] tag_q;
    logic             carry_q;
    logic             ready_c;
    logic [WIDTH-1:0] shifted;

    // Slot accepts when empty or when its content moves on this cycle.
    assign ready_c = !valid_q || out_ready;

    always_comb begin
        shifted = din;
        if (sh) begin
            case (op_in)
                OP_ROL:  shifted = (din << AMT) | (din >> (WIDTH - AMT));
                OP_SLL:  shifted = din << AMT;
                OP_ROR:  shifted = (din >> AMT) | (din << (WIDTH - AMT));
                OP_SRL:  shifted = din >> AMT;
                OP_SRA:  shifted = $unsigned($signed(din) >>> AMT);
                default: shifted = din;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            op_q    <= '0;
            cnt_q   <= '0;
            tag_q   <= '0;
            carry_q <= 1'b0;
        end else if (ready_c) begin
            valid_q <= in_valid;
            if (in_valid) begin
                data_q  <= shifted;
                op_q    <= op_in;
                cnt_q   <= cnt_in;
                tag_q   <= tag_in;
                carry_q <= carry_in;
            end
        end
    end

    assign out_valid = valid_q;
    assign dout      = data_q;
    assign op_out    = op_q;
    assign cnt_out   = cnt_q;
    assign tag_out   = tag_q;
    assign carry_out = carry_q;

endmodule

// File: rtl/shifter_pipe.sv
// Fully pipelined barrel shifter: one shift level per register stage, valid/ready flow control,
// tag passthrough, carry computed at entry and zero flag decoded from the final register.
module shifter_pipe
    import shifter_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned TAG_W = 4,
    localparam int unsigned CNT_W = clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] In,
    input  logic [CNT_W-1:0] Cnt,
    input  logic [2:0]       Op,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Out,
    output logic             out_carry,
    output logic             out_zero,
    output logic [TAG_W-1:0] out_tag
);

    logic [CNT_W:0][WIDTH-1:0] d;
    logic [CNT_W:0][2:0]       o;
    logic [CNT_W:0][CNT_W-1:0] c;
    logic [CNT_W:0][TAG_W-1:0] t;
    logic [CNT_W:0]            cy;
    logic [CNT_W-1:0]          sv;
    logic [CNT_W-1:0]          dn_rdy;
    logic [CNT_W-1:0]          idx_l;
    logic [CNT_W-1:0]          idx_r;
    logic                      carry0;
    logic                      unused_tail;

    // Left-type ops shift out In[WIDTH-Cnt]; right-type ops shift out In[Cnt-1].
    always_comb begin
        idx_l  = ~Cnt + CNT_W'(1);
        idx_r  = Cnt - CNT_W'(1);
        carry0 = 1'b0;
        if (Cnt != '0) begin
            case (Op)
                OP_ROL, OP_SLL:         carry0 = In[idx_l];
                OP_ROR, OP_SRL, OP_SRA: carry0 = In[idx_r];
                default:                carry0 = 1'b0;
            endcase
        end
    end

    assign d[0]  = In;
    assign o[0]  = Op;
    assign c[0]  = Cnt;
    assign t[0]  = in_tag;
    assign cy[0] = carry0;

    // Ready for a stage is flat-decoded from downstream valids to keep the chain acyclic.
    assign in_ready = out_ready | ~(&sv);

    for (genvar k = 0; k < CNT_W; k++) begin : g_stage
        logic vin;

        if (k == 0) begin : g_first
            assign vin = in_valid;
        end else begin : g_next
            assign vin = sv[k-1];
        end

        if (k == CNT_W - 1) begin : g_last
            assign dn_rdy[k] = out_ready;
        end else begin : g_mid
            assign dn_rdy[k] = out_ready | ~(&sv[CNT_W-1:k+1]);
        end

        shift_stage #(
            .WIDTH (WIDTH),
            .TAG_W (TAG_W),
            .AMT   (1 << k)
        ) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (vin),
            .din       (d[k]),
            .op_in     (o[k]),
            .cnt_in    (c[k]),
            .tag_in    (t[k]),
            .carry_in  (cy[k]),
            .sh        (c[k][k]),
            .out_ready (dn_rdy[k]),
            .out_valid (sv[k]),
            .dout      (d[k+1]),
            .op_out    (o[k+1]),
            .cnt_out   (c[k+1]),
            .tag_out   (t[k+1]),
            .carry_out (cy[k+1])
        );
    end

    assign out_valid = sv[CNT_W-1];
    assign Out       = d[CNT_W];
    assign out_carry = cy[CNT_W];
    assign out_tag   = t[CNT_W];
    assign out_zero  = (d[CNT_W] == '0);

    // Op and count are fully consumed by the time they leave the last stage.
    assign unused_tail = ^{o[CNT_W], c[CNT_W]};

endmodule

// File: doc/shifter_pipe.md
# shifter_pipe

Parametrised, fully pipelined barrel shifter for the datapath: one shift level per pipeline stage, any width that is a power of two, with valid/ready flow control, sideband tag passthrough and carry/zero flags. Replaces the 16-bit combinational shifter wherever execute-stage timing or multi-issue throughput requires a registered shifter. Sustains one operation per cycle; latency equals the number of shift levels.

## Interface
- WIDTH, 16: data width; power of two, 4..64
- TAG_W, 4: sideband tag width, carried unchanged with each operation
- CNT_W, log2(WIDTH): derived, not overridable; count width and pipeline depth
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operation offered
- in_ready  out  1  operation accepted when in_valid && in_ready
- In  in  WIDTH  operand
- Cnt  in  CNT_W  shift amount, 0..WIDTH-1
- Op  in  3  operation code
- in_tag  in  TAG_W  sideband
- out_valid  out  1  result present
- out_ready  in  1  result consumed when out_valid && out_ready
- Out  out  WIDTH  result
- out_carry  out  1  carry flag
- out_zero  out  1  result == 0
- out_tag  out  TAG_W  tag of this result

## Operation
- Op: 3'b000 ROL, 001 SLL, 010 ROR, 011 SRL (zero fill), 100 SRA (sign fill), 101–111 pass-through (Out = In, carry 0)
- Stage k (k = 0..CNT_W-1) applies a shift of 2^k when Cnt[k] = 1, then registers data, Op, remaining Cnt bits, tag, carry, valid
- Carry computed at input, piped alongside data: SLL In[WIDTH-Cnt]; SRL/SRA In[Cnt-1]; ROL final Out[0]; ROR final Out[WIDTH-1]; Cnt = 0 → 0 for all ops
- out_zero computed combinationally from the last stage's data register
- Per-stage flow: stage k loads when its register is empty or its downstream advances; ready_k = !valid_k || ready_{k+1}; last stage ready = out_ready; in_ready = ready_0
- Ready chain is combinational; no skid buffer; bubbles collapse (empty stage loads even while a later stage stalls)
- Order strictly preserved; no operation dropped or duplicated under any out_ready pattern
- Reset: all valid bits 0, all data/tag/flag registers 0 → out_valid 0, Out 0, out_carry 0, out_zero 1, out_tag 0, in_ready 1
- Reset asserted mid-stream discards all in-flight operations; first operation after deassertion behaves as if from reset

## Timing
- Latency: operation accepted at edge t appears on out_valid after edge t+CNT_W-1… defined as CNT_W register stages: WIDTH=16 → out_valid high in the 4th cycle after acceptance cycle (accepted cycle 0, visible cycle 4)
- Throughput: 1 op/cycle with out_ready held high
- out_ready low: last stage holds; in_ready falls only after all CNT_W stages hold valid data (capacity CNT_W ops)
- Simultaneous out_ready rise and new in_valid on a full pipe: both transfers occur in the same cycle
- Out, out_carry, out_zero, out_tag stable while out_valid && !out_ready
- in_ready has a combinational path from out_ready; no path from In/Cnt/Op to any output

## Structure
- Package shifter_pkg: Op encodings (OP_ROL, OP_SLL, OP_ROR, OP_SRL, OP_SRA), derived-width clog2 function
- Sub-module shift_stage (parameters WIDTH, TAG_W, AMT): one level's conditional shift plus registered valid/ready slot; shifter_pipe instantiates CNT_W of them via generate, plus input carry logic and output zero detect

## Test plan
- WIDTH=16, SLL In=16'h8001 Cnt=1 → Out 16'h0002, carry 1, zero 0, out_valid exactly 4 cycles after acceptance
- SRA In=16'h8000 Cnt=15 → Out 16'hFFFF, carry 0; SRL In=16'h0001 Cnt=1 → Out 16'h0000, carry 1, zero 1
- ROR In=16'h0001 Cnt=1 → Out 16'h8000, carry 1; ROL In=16'h1234 Cnt=4 → Out 16'h2341, carry 1; any op with Cnt=0 or Op=3'b101 → Out = In, carry 0
- 10 back-to-back ops with tags 0..9, out_ready low for cycles 5–9 → in_ready low after 4 held stages, all 10 results emerge in tag order, none lost, outputs stable while stalled
- rst_n pulsed low with 3 ops in flight → out_valid 0 immediately (asynchronous), Out 0, in_ready 1; next op completes normally with correct tag
- Random ops/counts/ready patterns at WIDTH=8, 16, 32 against a reference model → bit-exact Out, carry, zero, tag, order
